dfp_arbiter: RTL
================

# dfp_arbiter

Two-requester arbiter sharing one 256-bit downward memory port between the instruction-side and data-side mutative caches. Sits between each cache's dfp port and the main-memory model/bus adapter. Serialises full-line reads and write-backs, one outstanding transaction at a time, round-robin fairness. Registers each granted command so the memory side sees stable, glitch-free request signals.

## Interface
- ADDR_W, 32, byte address width
- LINE_W, 256, cacheline data width
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- req_addr[i]  in  ADDR_W  requester i line address, i∈{0,1}, 0=icache, 1=dcache
- req_read[i]  in  1  requester i line read
- req_write[i]  in  1  requester i line write-back
- req_wdata[i]  in  LINE_W  requester i write data
- req_rdata[i]  out  LINE_W  read data to requester i
- req_resp[i]  out  1  completion pulse to requester i
- mem_addr  out  ADDR_W  memory address (registered)
- mem_read  out  1  memory read (registered)
- mem_write  out  1  memory write (registered)
- mem_wdata  out  LINE_W  memory write data (registered)
- mem_rdata  in  LINE_W  memory read data
- mem_resp  in  1  memory completion, one cycle

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: pending[i] = req_read[i] | req_write[i]. None pending → stay. One pending → grant it. Both pending → grant ~last_grant. On grant: latch addr, wdata, op (write wins if both read and write set; illegal, not flagged), set last_grant, go BUSY.
- BUSY: mem_read/mem_write held from latched op, addr/wdata stable. On mem_resp: req_resp[grant]=1 same cycle, req_rdata[grant]=mem_rdata (pass-through); go DONE.
- DONE: one turnaround cycle, mem_read/mem_write low, then IDLE.
- req_rdata[non-granted] = 0; req_resp only ever to granted requester.
- Requesters hold request stable until their req_resp and deassert the cycle after; a request still high in IDLE after DONE is treated as a new request.
- mem_resp in IDLE or DONE: ignored, no req_resp.
- last_grant reset value 1, so first simultaneous contention grants requester 0.

## Timing
- Reset (async assert): state IDLE, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0, req_resp=0, req_rdata=0, last_grant=1. Reset mid-BUSY aborts the transaction; no req_resp issued.
- Request high at IDLE edge N → mem_read/mem_write high from N+1.
- mem_resp at cycle M → req_resp in M (combinational), mem command low from M+1 (DONE), earliest next mem command M+3.
- Minimum transaction: 3 cycles from grant to next grant with 1-cycle memory.
- Back-to-back contention strictly alternates 0,1,0,1…; a lone requester may be granted consecutively.
- No starvation: a continuously pending requester is granted within one other transaction.

## Configuration
- DFP_ARB_PERF_EN defined: 32-bit saturating counters grant_cnt[0], grant_cnt[1] (increment on grant) and conflict_cnt (increment each IDLE cycle with both pending, or BUSY cycle with the non-granted requester pending), reset to 0, exposed as outputs perf_grant0, perf_grant1, perf_conflict.
- Undefined: counters and those ports absent; all other behaviour identical.

## Test plan
- Single read: req_read[0]=1, addr 0x0000_1040, mem_resp 4 cycles after mem_read, mem_rdata=0xA5…A5 → mem_addr=0x0000_1040, req_resp[0] one cycle with req_rdata[0]=0xA5…A5, req_resp[1]=0.
- Simultaneous first contention: req_read[0] and req_write[1] same cycle → requester 0 served first, then requester 1 write with mem_wdata equal to req_wdata[1]; order 0,1.
- Sustained contention: both requesters reissue immediately after each resp for 8 transactions → grants alternate exactly, 4 each; with DFP_ARB_PERF_EN, perf_grant0=perf_grant1=4.
- Stray response: mem_resp pulsed in IDLE and in DONE → no req_resp, state unchanged.
- Reset mid-transaction: rst low while BUSY with mem_write=1 → mem_write=0 immediately, no req_resp; after release, a fresh req_read[1] is granted normally.
- Read+write both set on requester 1 → mem_write=1, mem_read=0.

Source files
------------

// File: rtl/dfp_arbiter.sv
// Round-robin arbiter sharing one cacheline memory port between icache (0) and dcache (1).
// Optional performance counters are built when DFP_ARB_PERF_EN is defined.
module dfp_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] req_addr  [2],
    input  logic [1:0]        req_read,
    input  logic [1:0]        req_write,
    input  logic [LINE_W-1:0] req_wdata [2],
    output logic [LINE_W-1:0] req_rdata [2],
    output logic [1:0]        req_resp,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read,
    output logic              mem_write,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp
`ifdef DFP_ARB_PERF_EN
    ,
    output logic [31:0]       perf_grant0,
    output logic [31:0]       perf_grant1,
    output logic [31:0]       perf_conflict
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic       grant_q;
    logic       grant_d;
    logic [1:0] pending;
    logic       take;
    logic       sel;
    logic       resp_fire;

    assign pending   = req_read | req_write;
    assign resp_fire = (state_q == BUSY) && mem_resp;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        take    = 1'b0;
        sel     = grant_q;
        case (state_q)
            IDLE: begin
                if (pending != 2'b00) begin
                    take    = 1'b1;
                    // Under contention the requester not served last time wins.
                    sel     = (pending == 2'b11) ? ~grant_q : pending[1];
                    grant_d = sel;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (mem_resp) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            grant_q <= 1'b1;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
        end
    end

    // Command register: loaded at grant, held through BUSY, dropped on completion.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
        end else if (take) begin
            mem_addr  <= req_addr[sel];
            mem_wdata <= req_wdata[sel];
            mem_write <= req_write[sel];
            mem_read  <= req_read[sel] & ~req_write[sel];
        end else if (resp_fire) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
        end
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            req_resp[i]  = resp_fire && (int'(grant_q) == i);
            req_rdata[i] = req_resp[i] ? mem_rdata : '0;
        end
    end

`ifdef DFP_ARB_PERF_EN
    logic [31:0] grant_cnt0_q;
    logic [31:0] grant_cnt1_q;
    logic [31:0] conflict_cnt_q;
    logic        conflict;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

    assign conflict = ((state_q == IDLE) && (pending == 2'b11)) ||
                      ((state_q == BUSY) && pending[~grant_q]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant_cnt0_q   <= '0;
            grant_cnt1_q   <= '0;
            conflict_cnt_q <= '0;
        end else begin
            if (take && !sel) grant_cnt0_q <= sat_inc(grant_cnt0_q);
            if (take && sel)  grant_cnt1_q <= sat_inc(grant_cnt1_q);
            if (conflict)     conflict_cnt_q <= sat_inc(conflict_cnt_q);
        end
    end

    assign perf_grant0   = grant_cnt0_q;
    assign perf_grant1   = grant_cnt1_q;
    assign perf_conflict = conflict_cnt_q;
`endif

endmodule
